intercore_mailbox: RTL and testbench
====================================

Name: intercore_mailbox

Overview:
- Parametrised inter-core message buffer between the two cores of MultiCore. It is the successor to the fixed 61-slot val_1/val_2/flag buffer.
- Provides NUM_CH independent circular FIFOs. Each entry is a pair of WIDTH-bit words (val1, val2).
- Producer core pushes into a selected channel; consumer core pops from a selected channel.
- Full/empty status is used by the cores to stall on blocking send/receive.

Parameters:
- WIDTH, 32, width of each data word.
- DEPTH, 4, entries per channel; power of 2, minimum 2.
- NUM_CH, 2, number of channels; minimum 2.
- Derived localparams: CH_W = clog2(NUM_CH); PTR_W = clog2(DEPTH); CNT_W = PTR_W+1.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request.
- wr_ch  in  CH_W  target channel for push.
- wr_val1  in  WIDTH  first word of pushed entry.
- wr_val2  in  WIDTH  second word of pushed entry.
- wr_stall  out  1  combinational; wr_en=1 and push not accepted this cycle.
- rd_en  in  1  pop request.
- rd_ch  in  CH_W  source channel for pop.
- rd_val1  out  WIDTH  head entry word 1 of rd_ch (show-ahead).
- rd_val2  out  WIDTH  head entry word 2 of rd_ch (show-ahead).
- rd_valid  out  1  channel rd_ch is non-empty.
- rd_stall  out  1  combinational; rd_en=1 and channel rd_ch is empty.
- ch_empty  out  NUM_CH  per-channel empty flag; bit i = channel i.
- ch_full  out  NUM_CH  per-channel full flag.
- ch_count  out  NUM_CH*CNT_W  flattened occupancy; channel i at [i*CNT_W +: CNT_W].
- err_sticky  out  2  bit0 = push to full or out-of-range channel; bit1 = pop from empty or out-of-range channel.

Behaviour:
- Reset (asynchronous, active-high), entered immediately, including mid-operation:
  - all head/tail pointers and counts = 0; ch_empty = all 1s; ch_full = 0; err_sticky = 0.
  - Storage contents are not reset. rd_val1/rd_val2 are don't-care while rd_valid = 0.
  - Bench must treat rd_val as X-tolerant when rd_valid = 0.
- Per-channel state:
  - tail pointer, head pointer (both PTR_W bits, wrap modulo DEPTH), and count (CNT_W bits).
  - empty = (count == 0); full = (count == DEPTH).
- Read path:
  - Zero latency: rd_val1/rd_val2 = mem[rd_ch][head[rd_ch]] combinationally; rd_valid = ~empty[rd_ch].
- Push accept:
  - accepted when wr_en & (wr_ch < NUM_CH) & (~full[wr_ch] | pop_acc_same).
  - pop_acc_same = pop accepted this cycle on the same channel. Pass-through while full is allowed.
  - On accept at posedge: write mem[wr_ch][tail]; tail += 1 (wrap).
- Pop accept:
  - accepted when rd_en & (rd_ch < NUM_CH) & ~empty[rd_ch].
  - No bypass: a push into an empty channel is not poppable in the same cycle.
  - On accept at posedge: head += 1 (wrap).
- Count update per channel:
  - +1 on push only; -1 on pop only; unchanged when both occur or neither occurs.
- Simultaneous push/pop on different channels: fully independent.
- Rejected push or pop:
  - no state change, stall asserted the same cycle, and the matching err_sticky bit is set at posedge.
  - Out-of-range channel (possible only when NUM_CH is not a power of 2) is rejected the same way.
- Stalls are combinational. The cores hold the request stable until the stall drops. There is no request queuing.
- err_sticky bits clear only on Reset.

Decomposition:
- Shared package mailbox_pkg holds:
  - clog2 function;
  - default WIDTH/DEPTH/NUM_CH constants;
  - err_sticky bit index constants ERR_PUSH = 0, ERR_POP = 1.
- One natural sub-module: mailbox_channel, a single circular FIFO.
  - Ports: push, pop, din1, din2, dout1, dout2, empty, full, count.
  - Instantiated NUM_CH times by a generate loop.
  - Top level holds channel decode, accept logic, stall/error logic and output flattening.

Test Plan (NUM_CH=2, DEPTH=4, WIDTH=32):
- Reset held 3 cycles, then released -> ch_empty=2'b11, ch_full=0, ch_count=0, err_sticky=0, rd_valid=0.
- Push A1/A2=0x11/0x22 then 0x33/0x44 to ch0, and 0xAA/0xBB to ch1 -> ch_count ch0=2, ch1=1. rd_ch=0 shows 0x11/0x22. Pop ch0 once -> shows 0x33/0x44, count=1.
- Fill ch0 with 4 entries, then push 5th 0x55/0x66 -> wr_stall=1, err_sticky[0]=1, count stays 4, ch_full[0]=1. Same push concurrent with a ch0 pop -> accepted, count stays 4, FIFO order preserved.
- Wrap-around: push/pop ch1 9 times with values 1..9 -> pops return 1..9 in order, count ends at 0.
- Pop from empty ch1 -> rd_stall=1, err_sticky[1]=1, no pointer change. Push to empty ch1 with concurrent ch1 pop -> pop stalls; next cycle rd_valid=1.
- Assert Reset asynchronously mid-burst, between clock edges -> flags clear before the next posedge. Subsequent pushes start from count=0.

Source files
------------

// File: rtl/mailbox_pkg.sv
// Shared constants and helpers for the inter-core mailbox.
package mailbox_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_DEPTH  = 4;
  localparam int unsigned DEFAULT_NUM_CH = 2;

  // Bit positions inside err_sticky.
  localparam int unsigned ERR_PUSH = 0;
  localparam int unsigned ERR_POP  = 1;

  // Ceiling log2, never below 1 so derived vectors always have a legal width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mailbox_channel.sv
// One circular FIFO of (val1, val2) pairs with show-ahead head output.
// Push/pop arrive already qualified by the top level (never push-when-full
// without a same-cycle pop, never pop-when-empty).
module mailbox_channel
  import mailbox_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [WIDTH-1:0] mem2 [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage write; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem1[tail_q] <= din1;
      mem2[tail_q] <= din2;
    end
  end

  assign dout1 = mem1[head_q];
  assign dout2 = mem2[head_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/intercore_mailbox.sv
// Multi-channel inter-core mailbox: channel decode, accept/stall logic,
// sticky error flags and flattening of per-channel status.
module intercore_mailbox
  import mailbox_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
  localparam int unsigned CH_W  = clog2(NUM_CH),
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [WIDTH-1:0]        wr_val1,
  input  logic [WIDTH-1:0]        wr_val2,
  output logic                    wr_stall,
  input  logic                    rd_en,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [WIDTH-1:0]        rd_val1,
  output logic [WIDTH-1:0]        rd_val2,
  output logic                    rd_valid,
  output logic                    rd_stall,
  output logic [NUM_CH-1:0]       ch_empty,
  output logic [NUM_CH-1:0]       ch_full,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic [1:0]              err_sticky
);

  logic [NUM_CH-1:0] wr_sel, rd_sel, push_go, pop_go;
  logic [NUM_CH-1:0] empty, full;
  logic [WIDTH-1:0]  dout1 [NUM_CH];
  logic [WIDTH-1:0]  dout2 [NUM_CH];
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [1:0]        err_q;

  // Decode requests per channel; an out-of-range channel matches no bit and so
  // is never accepted. A full channel still takes a push if it pops this cycle.
  always_comb begin
    wr_sel  = '0;
    rd_sel  = '0;
    pop_go  = '0;
    push_go = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i]  = wr_en && (wr_ch == CH_W'(i));
      rd_sel[i]  = rd_en && (rd_ch == CH_W'(i));
      pop_go[i]  = rd_sel[i] && !empty[i];
      push_go[i] = wr_sel[i] && (!full[i] || pop_go[i]);
    end
  end

  // Show-ahead read mux for the selected consumer channel.
  always_comb begin
    rd_val1  = '0;
    rd_val2  = '0;
    rd_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_val1  = dout1[i];
        rd_val2  = dout2[i];
        rd_valid = !empty[i];
      end
    end
  end

  assign wr_stall = wr_en && !(|push_go);
  assign rd_stall = rd_en && !(|pop_go);

  // Sticky error capture; cleared only by reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= '0;
    end else begin
      if (wr_stall) err_q[ERR_PUSH] <= 1'b1;
      if (rd_stall) err_q[ERR_POP]  <= 1'b1;
    end
  end

  assign err_sticky = err_q;
  assign ch_empty   = empty;
  assign ch_full    = full;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mailbox_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_channel (
      .clk   (Clk),
      .rst   (Reset),
      .push  (push_go[g]),
      .pop   (pop_go[g]),
      .din1  (wr_val1),
      .din2  (wr_val2),
      .dout1 (dout1[g]),
      .dout2 (dout2[g]),
      .empty (empty[g]),
      .full  (full[g]),
      .count (count[g])
    );
    assign ch_count[g*CNT_W +: CNT_W] = count[g];
  end

endmodule

// File: tb/tb_intercore_mailbox.sv
// Self-checking bench for intercore_mailbox (NUM_CH=2, DEPTH=4, WIDTH=32).
// Queues q0/q1 hold the expected contents of each channel.
module tb_intercore_mailbox;

  localparam int W    = 32;
  localparam int D    = 4;
  localparam int N    = 2;
  localparam int CW   = 1;
  localparam int CNTW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en, rd_en;
  logic [CW-1:0]     wr_ch, rd_ch;
  logic [W-1:0]      wr_val1, wr_val2, rd_val1, rd_val2;
  logic              wr_stall, rd_stall, rd_valid;
  logic [N-1:0]      ch_empty, ch_full;
  logic [N*CNTW-1:0] ch_count;
  logic [1:0]        err_sticky;

  int checks = 0;
  int errors = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [1:0]  merr;

  intercore_mailbox #(
    .WIDTH  (W),
    .DEPTH  (D),
    .NUM_CH (N)
  ) dut (
    .Clk        (clk),
    .Reset      (reset),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_val1    (wr_val1),
    .wr_val2    (wr_val2),
    .wr_stall   (wr_stall),
    .rd_en      (rd_en),
    .rd_ch      (rd_ch),
    .rd_val1    (rd_val1),
    .rd_val2    (rd_val2),
    .rd_valid   (rd_valid),
    .rd_stall   (rd_stall),
    .ch_empty   (ch_empty),
    .ch_full    (ch_full),
    .ch_count   (ch_count),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [63:0] qfront(input int ch);
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".empty"}, 64'(ch_empty), 64'({q1.size() == 0, q0.size() == 0}));
    check({tag, ".full"}, 64'(ch_full), 64'({q1.size() == D, q0.size() == D}));
    check({tag, ".count"}, 64'(ch_count), 64'({3'(q1.size()), 3'(q0.size())}));
    check({tag, ".err"}, 64'(err_sticky), 64'(merr));
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input string tag, input logic we, input int wc, input logic [31:0] v1,
                      input logic [31:0] v2, input logic re, input int rc);
    bit pop_ok, push_ok;
    wr_en   = we;
    wr_ch   = CW'(wc);
    wr_val1 = v1;
    wr_val2 = v2;
    rd_en   = re;
    rd_ch   = CW'(rc);
    #2;
    pop_ok  = re && (qsize(rc) > 0);
    push_ok = we && ((qsize(wc) < D) || (pop_ok && (rc == wc)));
    check({tag, ".rd_valid"}, 64'(rd_valid), 64'(qsize(rc) > 0));
    if (qsize(rc) > 0) check({tag, ".rd_val"}, {rd_val1, rd_val2}, qfront(rc));
    check({tag, ".wr_stall"}, 64'(wr_stall), 64'(we && !push_ok));
    check({tag, ".rd_stall"}, 64'(rd_stall), 64'(re && !pop_ok));
    @(posedge clk);
    #1;
    if (pop_ok) begin
      if (rc == 0) void'(q0.pop_front());
      else         void'(q1.pop_front());
    end
    if (push_ok) begin
      if (wc == 0) q0.push_back({v1, v2});
      else         q1.push_back({v1, v2});
    end
    if (we && !push_ok) merr[0] = 1'b1;
    if (re && !pop_ok)  merr[1] = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_status(tag);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_ch   = '0;
    rd_ch   = '0;
    wr_val1 = '0;
    wr_val2 = '0;
    merr    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_status("reset");
    check("reset.rd_valid", 64'(rd_valid), 64'(0));
    @(posedge clk);
    #1;

    // Basic pushes and show-ahead read.
    step("push0a", 1, 0, 32'h11, 32'h22, 0, 0);
    step("push0b", 1, 0, 32'h33, 32'h44, 0, 0);
    step("push1a", 1, 1, 32'hAA, 32'hBB, 0, 0);
    step("show0", 0, 0, 0, 0, 0, 0);
    step("pop0", 0, 0, 0, 0, 1, 0);
    step("show0b", 0, 0, 0, 0, 0, 0);

    // Fill ch0, overflow, then pass-through push while full.
    for (int i = 0; i < 3; i++) step("fill0", 1, 0, 32'h100 + i, 32'h200 + i, 0, 0);
    step("ovf0", 1, 0, 32'h55, 32'h66, 0, 0);
    step("pass0", 1, 0, 32'h55, 32'h66, 1, 0);
    for (int i = 0; i < 4; i++) step("drain0", 0, 0, 0, 0, 1, 0);

    // Drain ch1, then wrap its pointers with values 1..9.
    step("drain1", 0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 9; i++) begin
      step("wrap.push", 1, 1, i, 32'h1000 + i, 0, 1);
      step("wrap.pop", 0, 1, 0, 0, 1, 1);
    end

    // Pop from empty, then push into empty with same-cycle pop (no bypass).
    step("popempty", 0, 0, 0, 0, 1, 1);
    step("nobypass", 1, 1, 32'h77, 32'h88, 1, 1);
    step("nobypass.next", 0, 0, 0, 0, 0, 1);

    // Randomised traffic on both channels.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges during a burst.
    step("burst", 1, 0, 32'hC0, 32'hC1, 0, 0);
    step("burst", 1, 1, 32'hC2, 32'hC3, 1, 1);
    wr_en = 1'b1;
    wr_ch = '0;
    #2;
    reset = 1'b1;
    #1;
    wr_en = 1'b0;
    q0.delete();
    q1.delete();
    merr = '0;
    check_status("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("after_rst", 1, 0, 32'hD0, 32'hD1, 0, 0);
    step("after_rst.show", 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
